// File: rtl/id_ex_pipeline_reg_if.sv
// ID-side payload into the ID/EX register and the registered EX-side payload out of it.
// The master drives the decoded instruction plus flush/ext_stall; the slave returns id_ex_*, hazard_stall and bubble_count.
interface id_ex_pipeline_reg_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [XLEN-1:0]     id_pc;
    logic [XLEN-1:0]     id_rs1_data;
    logic [XLEN-1:0]     id_rs2_data;
    logic [XLEN-1:0]     id_imm;
    logic [4:0]          id_rs1_addr;
    logic [4:0]          id_rs2_addr;
    logic [4:0]          id_rd_addr;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                id_alu_src;
    logic                id_branch;
    logic                id_jump;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic                flush;
    logic                ext_stall;

    logic                id_ex_valid;
    logic [XLEN-1:0]     id_ex_pc;
    logic [XLEN-1:0]     id_ex_rs1_data;
    logic [XLEN-1:0]     id_ex_rs2_data;
    logic [XLEN-1:0]     id_ex_imm;
    logic [4:0]          id_ex_rs1_addr;
    logic [4:0]          id_ex_rs2_addr;
    logic [4:0]          id_ex_rd_addr;
    logic                id_ex_reg_write;
    logic                id_ex_mem_read;
    logic                id_ex_mem_write;
    logic                id_ex_mem_to_reg;
    logic                id_ex_alu_src;
    logic                id_ex_branch;
    logic                id_ex_jump;
    logic [ALU_OP_W-1:0] id_ex_alu_op;
    logic                hazard_stall;
    logic [CNT_W-1:0]    bubble_count;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_jump, id_alu_op, flush, ext_stall,
        input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
               id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_alu_op,
               hazard_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_jump, id_alu_op, flush, ext_stall,
        output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
               id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_alu_op,
               hazard_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX register with load-use detection; ID payload appears on id_ex_* one cycle after capture.
// flush loads a bubble, ext_stall freezes everything, a load-use hit loads a counted bubble and raises hazard_stall.
module id_ex_pipeline_reg #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst_n,
    id_ex_pipeline_reg_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic [4:0]          rd_addr;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } stage_t;

    stage_t           id_stage;
    stage_t           ex_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    // An invalid ID slot is captured as an all-zero bubble so forwarding never matches it.
    always_comb begin
        id_stage = '0;
        if (bus.id_valid) begin
            id_stage.valid      = 1'b1;
            id_stage.pc         = bus.id_pc;
            id_stage.rs1_data   = bus.id_rs1_data;
            id_stage.rs2_data   = bus.id_rs2_data;
            id_stage.imm        = bus.id_imm;
            id_stage.rs1_addr   = bus.id_rs1_addr;
            id_stage.rs2_addr   = bus.id_rs2_addr;
            id_stage.rd_addr    = bus.id_rd_addr;
            id_stage.reg_write  = bus.id_reg_write;
            id_stage.mem_read   = bus.id_mem_read;
            id_stage.mem_write  = bus.id_mem_write;
            id_stage.mem_to_reg = bus.id_mem_to_reg;
            id_stage.alu_src    = bus.id_alu_src;
            id_stage.branch     = bus.id_branch;
            id_stage.jump       = bus.id_jump;
            id_stage.alu_op     = bus.id_alu_op;
        end
    end

    assign rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1_addr == ex_q.rd_addr);
    assign rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2_addr == ex_q.rd_addr);
    assign load_use = bus.id_valid && ex_q.valid && ex_q.mem_read &&
                      (ex_q.rd_addr != 5'd0) && (rs1_hit || rs2_hit);

    // Upstream already holds on ext_stall, and a flushed ID instruction is dead, so neither needs hazard_stall.
    assign bus.hazard_stall = load_use && !bus.flush && !bus.ext_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.ext_stall) begin
            ex_q         <= ex_q;
            bubble_cnt_q <= bubble_cnt_q;
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end else begin
            ex_q <= id_stage;
        end
    end

    assign bus.id_ex_valid      = ex_q.valid;
    assign bus.id_ex_pc         = ex_q.pc;
    assign bus.id_ex_rs1_data   = ex_q.rs1_data;
    assign bus.id_ex_rs2_data   = ex_q.rs2_data;
    assign bus.id_ex_imm        = ex_q.imm;
    assign bus.id_ex_rs1_addr   = ex_q.rs1_addr;
    assign bus.id_ex_rs2_addr   = ex_q.rs2_addr;
    assign bus.id_ex_rd_addr    = ex_q.rd_addr;
    assign bus.id_ex_reg_write  = ex_q.reg_write;
    assign bus.id_ex_mem_read   = ex_q.mem_read;
    assign bus.id_ex_mem_write  = ex_q.mem_write;
    assign bus.id_ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.id_ex_alu_src    = ex_q.alu_src;
    assign bus.id_ex_branch     = ex_q.branch;
    assign bus.id_ex_jump       = ex_q.jump;
    assign bus.id_ex_alu_op     = ex_q.alu_op;
    assign bus.bubble_count     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed then randomized instruction streams checked against an instruction-level pipeline model.
module tb_id_ex_pipeline_reg;

    localparam int K_LOAD  = 0;
    localparam int K_ALU   = 1;
    localparam int K_STORE = 2;
    localparam int K_LUI   = 3;
    localparam int K_BR    = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic [3:0]  alu_op;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_t  drv;
    logic drv_uses1, drv_uses2, drv_flush, drv_stall;
    ex_t  exp_ex;
    ex_t  dut_ex;
    int   n_bub;
    int   n_cmp  = 0;
    int   n_fail = 0;

    id_ex_pipeline_reg_if #(.XLEN(32), .ALU_OP_W(4), .CNT_W(16)) bus  ();
    id_ex_pipeline_reg_if #(.XLEN(32), .ALU_OP_W(4), .CNT_W(2))  bus2 ();

    id_ex_pipeline_reg #(.XLEN(32), .ALU_OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    id_ex_pipeline_reg #(.XLEN(32), .ALU_OP_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    assign {bus.id_valid, bus.id_pc, bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
            bus.id_rs1_addr, bus.id_rs2_addr, bus.id_rd_addr,
            bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg,
            bus.id_alu_src, bus.id_branch, bus.id_jump, bus.id_alu_op} = drv;
    assign {bus2.id_valid, bus2.id_pc, bus2.id_rs1_data, bus2.id_rs2_data, bus2.id_imm,
            bus2.id_rs1_addr, bus2.id_rs2_addr, bus2.id_rd_addr,
            bus2.id_reg_write, bus2.id_mem_read, bus2.id_mem_write, bus2.id_mem_to_reg,
            bus2.id_alu_src, bus2.id_branch, bus2.id_jump, bus2.id_alu_op} = drv;
    assign bus.id_uses_rs1  = drv_uses1;
    assign bus.id_uses_rs2  = drv_uses2;
    assign bus.flush        = drv_flush;
    assign bus.ext_stall    = drv_stall;
    assign bus2.id_uses_rs1 = drv_uses1;
    assign bus2.id_uses_rs2 = drv_uses2;
    assign bus2.flush       = drv_flush;
    assign bus2.ext_stall   = drv_stall;

    assign dut_ex = {bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_rs1_data, bus.id_ex_rs2_data,
                     bus.id_ex_imm, bus.id_ex_rs1_addr, bus.id_ex_rs2_addr, bus.id_ex_rd_addr,
                     bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
                     bus.id_ex_mem_to_reg, bus.id_ex_alu_src, bus.id_ex_branch,
                     bus.id_ex_jump, bus.id_ex_alu_op};

    task automatic check(input string tag, input logic [154:0] obs, input logic [154:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds one decoded RV32I-style instruction in the ID slot.
    task automatic set_instr(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2);
        drv          = '0;
        drv.valid    = 1'b1;
        drv.pc       = $urandom;
        drv.rs1_data = $urandom;
        drv.rs2_data = $urandom;
        drv.imm      = $urandom;
        drv.rd_addr  = rd;
        drv.rs1_addr = rs1;
        drv.rs2_addr = rs2;
        drv.alu_op   = 4'($urandom_range(0, 15));
        drv_uses1 = 1'b0;
        drv_uses2 = 1'b0;
        drv_flush = 1'b0;
        drv_stall = 1'b0;
        case (kind)
            K_LOAD:  begin drv.mem_read = 1'b1; drv.reg_write = 1'b1; drv.mem_to_reg = 1'b1;
                           drv.alu_src = 1'b1; drv_uses1 = 1'b1; end
            K_ALU:   begin drv.reg_write = 1'b1; drv_uses1 = 1'b1; drv_uses2 = 1'b1; end
            K_STORE: begin drv.mem_write = 1'b1; drv.alu_src = 1'b1;
                           drv_uses1 = 1'b1; drv_uses2 = 1'b1; end
            K_LUI:   begin drv.reg_write = 1'b1; drv.alu_src = 1'b1; end
            default: begin drv.branch = 1'b1; drv_uses1 = 1'b1; drv_uses2 = 1'b1; end
        endcase
    endtask

    // One clock: check the combinational stall, advance the model, check the registered state.
    task automatic step();
        logic lu;
        int   sat;
        #1;
        lu = drv.valid && exp_ex.valid && exp_ex.mem_read && (exp_ex.rd_addr != 5'd0) &&
             ((drv_uses1 && drv.rs1_addr == exp_ex.rd_addr) ||
              (drv_uses2 && drv.rs2_addr == exp_ex.rd_addr));
        check("hazard_stall", 155'(bus.hazard_stall), 155'(lu && !drv_flush && !drv_stall));
        @(posedge clk);
        if (drv_flush)       exp_ex = '0;
        else if (drv_stall)  exp_ex = exp_ex;
        else if (lu)         begin exp_ex = '0; n_bub++; end
        else                 exp_ex = drv.valid ? drv : '0;
        @(negedge clk);
        sat = (n_bub > 3) ? 3 : n_bub;
        check("id_ex_payload", 155'(dut_ex), 155'(exp_ex));
        check("bubble_count", 155'(bus.bubble_count), 155'(n_bub));
        check("bubble_count_cnt2", 155'(bus2.bubble_count), 155'(sat));
    endtask

    initial begin
        // Reset with every input driven high.
        rst_n = 1'b0;
        drv = '1; drv_uses1 = 1'b1; drv_uses2 = 1'b1; drv_flush = 1'b1; drv_stall = 1'b1;
        exp_ex = '0;
        n_bub  = 0;
        repeat (2) @(negedge clk);
        check("reset_payload", 155'(dut_ex), 155'(0));
        check("reset_hazard", 155'(bus.hazard_stall), 155'(0));
        check("reset_count", 155'(bus.bubble_count), 155'(0));

        rst_n = 1'b1;
        drv = '0; drv_uses1 = 1'b0; drv_uses2 = 1'b0; drv_flush = 1'b0; drv_stall = 1'b0;
        drv.valid = 1'b1; drv.rd_addr = 5'd5; drv.pc = 32'h100;
        step();
        check("first_rd", 155'(bus.id_ex_rd_addr), 155'(5));
        check("first_pc", 155'(bus.id_ex_pc), 155'(32'h100));

        // lw x5 then add x6,x5,x7: one bubble, then the add.
        set_instr(K_LOAD, 5'd5, 5'd1, 5'd0); step();
        set_instr(K_ALU, 5'd6, 5'd5, 5'd7);
        #1 check("lu_hazard_direct", 155'(bus.hazard_stall), 155'(1));
        step();
        check("lu_bubble_valid", 155'(bus.id_ex_valid), 155'(0));
        check("lu_bubble_count", 155'(bus.bubble_count), 155'(1));
        step();
        check("lu_add_rs1", 155'(bus.id_ex_rs1_addr), 155'(5));

        // Loads to x0 and consumers without source reads never stall.
        set_instr(K_LOAD, 5'd0, 5'd1, 5'd0); step();
        set_instr(K_ALU, 5'd1, 5'd0, 5'd0);  step();
        set_instr(K_LOAD, 5'd5, 5'd1, 5'd0); step();
        set_instr(K_LUI, 5'd5, 5'd5, 5'd5);  step();

        // Store data register matching the load destination still stalls.
        set_instr(K_LOAD, 5'd9, 5'd1, 5'd0);  step();
        set_instr(K_STORE, 5'd0, 5'd2, 5'd9); step(); step();

        // flush beats ext_stall and load-use.
        set_instr(K_LOAD, 5'd5, 5'd1, 5'd0); step();
        set_instr(K_ALU, 5'd6, 5'd5, 5'd5);
        drv_flush = 1'b1; drv_stall = 1'b1;
        step();

        // ext_stall for 3 cycles with changing inputs, entered with load-use pending.
        set_instr(K_LOAD, 5'd7, 5'd1, 5'd0); step();
        for (int i = 0; i < 3; i++) begin
            set_instr(K_ALU, 5'd8, 5'd7, 5'd2);
            drv_stall = 1'b1;
            step();
        end
        set_instr(K_ALU, 5'd8, 5'd7, 5'd2); step(); step();

        // Async reset in the middle of a stall leaves nothing pending.
        set_instr(K_LOAD, 5'd5, 5'd1, 5'd0); step();
        set_instr(K_ALU, 5'd6, 5'd5, 5'd0);
        drv_stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_payload", 155'(dut_ex), 155'(0));
        check("midreset_count", 155'(bus.bubble_count), 155'(0));
        check("midreset_hazard", 155'(bus.hazard_stall), 155'(0));
        exp_ex = '0;
        n_bub  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(K_ALU, 5'd6, 5'd5, 5'd0); step();

        // Five dependent pairs walk the 2-bit counter through 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            set_instr(K_LOAD, 5'd3, 5'd1, 5'd0); step();
            set_instr(K_ALU, 5'd4, 5'd2, 5'd3);  step(); step();
        end
        check("sat_full_count", 155'(bus.bubble_count), 155'(5));
        check("sat_cnt2_count", 155'(bus2.bubble_count), 155'(3));

        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = ($urandom_range(0, 2) == 0) ? K_LOAD : int'($urandom_range(0, 4));
            set_instr(kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) == 0) drv.valid = 1'b0;
            drv_flush = ($urandom_range(0, 9) == 0);
            drv_stall = ($urandom_range(0, 6) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
